key_event_uart_tx: RTL
======================

Name: key_event_uart_tx

Overview:
Downstream consumer of the keyboard scan-difference stage. It accepts the single-cycle key event pulses (`on_event` with an 8-bit `key_event` code: bit7 = release flag, bits6:0 = key index 0..102) and buffers them in a small FIFO. It then serialises each event to the host as one UART 8N1 frame. The FIFO absorbs bursts: the upstream stage can assert `on_event` on consecutive clocks during a single scan pass.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (434 = 115200 baud at 50 MHz); legal range 2..65535.
- ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (16 by default).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_event  input  8  event code; only meaningful while on_event=1.
- on_event  input  1  event strobe; one event per clock cycle in which it is high.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while FIFO non-empty or a frame is in progress.
- overflow  output  1  sticky flag: at least one event was dropped.
- fifo_count  output  ADDR_W+1  number of events currently buffered (0..2**ADDR_W).

Behaviour:
- Reset (async, active-high), while asserted and immediately on assertion:
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FIFO pointers cleared; FSM=IDLE; bit counter and divider=0.
  - A frame in flight is abandoned; no partial frame resumes after reset.
- FIFO write:
  - Write happens on a rising edge where on_event=1 and the FIFO was not full before that edge.
  - key_event is stored unmodified.
  - If on_event=1 while full, the event is dropped and overflow is set to 1. overflow stays 1 until reset.
  - Full is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs on the same edge.
  - When on_event=0, key_event is ignored (it is 0 upstream anyway).
- FIFO order is strict first-in, first-out. Pointers wrap modulo 2**ADDR_W. The ADDR_W+1-bit pointer difference gives fifo_count.
- Simultaneous push and pop when not full: both happen; fifo_count is unchanged.
- TX state machine, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. At an edge where fifo_count!=0, pop the head into an 8-bit shift register, clear the divider, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLK_DIV cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE.
  - The divider counts 0..CLK_DIV-1; a bit period ends at the edge where the divider = CLK_DIV-1.
- Latency: event sampled at edge N is written at N. IDLE pops at edge N+1, and tx falls immediately after N+1.
- Frame length is exactly 10*CLK_DIV cycles.
- Back-to-back frames have one IDLE cycle between them (tx=1), so the frame pitch is 10*CLK_DIV+1 cycles.
- tx is driven from a register: glitch-free, and it never changes between bit boundaries.
- busy = (state!=IDLE) or (fifo_count!=0), registered to match the state.
- FIFO storage has no reset requirement; pointers do.

Test Plan:
- Single event, CLK_DIV=4: key_event=0x85 with on_event for 1 cycle.
  - tx falls 1 cycle after the write.
  - Bits over 40 cycles: 0, 1,0,1,0,0,0,0,1, then 1.
  - busy drops after STOP; fifo_count goes 1->0 at the pop.
- Burst, CLK_DIV=4, ADDR_W=4: 5 consecutive on_event cycles with codes 0x00,0x01,0x02,0x03,0x83.
  - Five frames appear in order, each 41 cycles apart.
  - overflow stays 0.
- Overflow, CLK_DIV=4: 20 consecutive events 0x00..0x13.
  - Frames carry 0x00..0x10: 16 buffered plus the one popped early, letting 0x10 in.
  - Events 0x11..0x13 are dropped as the FIFO refills to full.
  - overflow goes 1 and stays 1.
  - The bench checks exact accepted codes against a reference model.
- Full + pop same edge: fill the FIFO to 16 while the FSM is in STOP. Assert on_event on the edge IDLE pops.
  - That event is dropped, overflow=1, fifo_count=15.
- Reset mid-frame: assert reset during DATA bit 3.
  - tx=1, busy=0, fifo_count=0 immediately.
  - After deassert with no input, tx stays 1 for 100 cycles.
- Idle inputs: key_event=0xFF with on_event=0 for 50 cycles.
  - No write occurs, fifo_count=0, tx=1.

Source files
------------

// File: rtl/key_event_uart_tx_if.sv
// Key event strobe bus from the scan-difference stage into the UART transmitter.
interface key_event_uart_tx_if;
  logic [7:0] key_event;
  logic       on_event;

  modport master (output key_event, output on_event);
  modport slave  (input  key_event, input  on_event);
endinterface

// File: rtl/key_event_uart_tx.sv
// Buffers key event codes in a FIFO and sends each one to the host as a UART 8N1 frame.
module key_event_uart_tx #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  key_event_uart_tx_if.slave  evt,
  output logic                tx,
  output logic                busy,
  output logic                overflow,
  output logic [ADDR_W:0]     fifo_count
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [2**ADDR_W];

  logic [ADDR_W:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            bit_end;

  // Occupancy comes from the pre-edge pointers, so a write while full is
  // dropped even when the transmitter pops on the same edge.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = count[ADDR_W];
  assign empty   = (count == '0);
  assign push    = evt.on_event && !full;
  assign pop     = (state_q == IDLE) && !empty;
  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (evt.on_event & full);

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
          rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
          div_d    = '0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          div_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    end

    busy_d = (state_d != IDLE) || ((wr_ptr_d - rd_ptr_d) != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= evt.key_event;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count;

endmodule
